// File: rtl/delay_measure_engine.sv
// delay_measure_engine
//
// Measures the propagation delay of one of CHANNELS asynchronous delay paths.
// Each run launches 2^TRIALS_LOG2 alternating rising and falling transitions
// into the selected path. For each transition it counts clock edges until a
// two-flop synchronised copy of the path output matches the launched level.
// It accumulates the sum, minimum and maximum of those trial counts. A trial
// that reaches TIMEOUT edges aborts the whole run.
//
// Ports
//   clk_i       single rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     run request, only sampled while idle
//   chan_sel_i  channel to measure, latched when a start is accepted
//   path_out_i  asynchronous delay-path outputs
//   path_in_o   registered launch drive into the delay paths
//   busy_o      high whenever a run is in progress (state is not idle)
//   done_o      one-cycle pulse at the end of a run
//   timeout_o   run was aborted; holds until the next accepted start or reset
//   sum_cnt_o   sum of trial counts
//   min_cnt_o   smallest trial count (all-ones before the first trial)
//   max_cnt_o   largest trial count
module delay_measure_engine #(
  parameter int CNT_W       = 32,
  parameter int CHANNELS    = 4,
  parameter int TRIALS_LOG2 = 4,
  parameter int TIMEOUT     = 1000,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_W      = CNT_W + TRIALS_LOG2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [SEL_W-1:0]    chan_sel_i,
  input  logic [CHANNELS-1:0] path_out_i,
  output logic [CHANNELS-1:0] path_in_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [SUM_W-1:0]    sum_cnt_o,
  output logic [CNT_W-1:0]    min_cnt_o,
  output logic [CNT_W-1:0]    max_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q,   state_d;
  logic [SEL_W-1:0]       chan_q,    chan_d;
  logic [CHANNELS-1:0]    path_in_q, path_in_d;
  logic [CHANNELS-1:0]    s1_q, s2_q;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [TRIALS_LOG2-1:0] trial_q,   trial_d;
  logic [SUM_W-1:0]       sum_q,     sum_d;
  logic [CNT_W-1:0]       min_q,     min_d;
  logic [CNT_W-1:0]       max_q,     max_d;
  logic                   timeout_q, timeout_d;

  logic                   sel_valid;
  logic                   sel_level;
  logic                   obs_level;
  logic                   launch_level;
  logic [CHANNELS-1:0]    sel_onehot;
  logic [CHANNELS-1:0]    chan_onehot;
  logic [CNT_W-1:0]       trial_val;

  // chan_sel_i may exceed CHANNELS-1 when CHANNELS is not a power of two.
  assign sel_valid = ({1'b0, chan_sel_i} < (SEL_W + 1)'(CHANNELS));

  // Channel multiplexers written as compare loops so that an out-of-range
  // select simply reads as level 0 / no one-hot bit instead of indexing
  // past the end of the vectors.
  always_comb begin
    sel_level    = 1'b0;
    obs_level    = 1'b0;
    launch_level = 1'b0;
    sel_onehot   = '0;
    chan_onehot  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_sel_i == SEL_W'(i)) begin
        sel_level     = s2_q[i];
        sel_onehot[i] = 1'b1;
      end
      if (chan_q == SEL_W'(i)) begin
        obs_level      = s2_q[i];
        launch_level   = path_in_q[i];
        chan_onehot[i] = 1'b1;
      end
    end
  end

  // Count for the current trial if it completes on this edge. It cannot wrap
  // because a trial never runs past TIMEOUT, which fits in CNT_W bits.
  assign trial_val = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    path_in_d = path_in_q;
    cnt_d     = cnt_q;
    trial_d   = trial_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        // The selected path must read low so the first rising launch is
        // a real transition.
        if (start_i && sel_valid && !sel_level) begin
          chan_d    = chan_sel_i;
          path_in_d = sel_onehot;
          cnt_d     = '0;
          trial_d   = '0;
          sum_d     = '0;
          min_d     = '1;
          max_d     = '0;
          timeout_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A match takes priority over the timeout, so a trial that
        // completes exactly at TIMEOUT edges still counts.
        if (obs_level == launch_level) begin
          sum_d = sum_q + SUM_W'(trial_val);
          if (trial_val < min_q) min_d = trial_val;
          if (trial_val > max_q) max_d = trial_val;
          if (trial_q == '1) begin
            // Even trial count: the drive is already low after the last
            // falling launch, so it is left untouched.
            state_d = ST_DONE;
          end else begin
            // Next launch on the same edge, no idle cycle between trials.
            path_in_d = path_in_q ^ chan_onehot;
            cnt_d     = '0;
            trial_d   = trial_q + TRIALS_LOG2'(1);
          end
        end else if (trial_val == CNT_W'(TIMEOUT)) begin
          path_in_d = '0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = trial_val;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      path_in_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      trial_q   <= '0;
      sum_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      path_in_q <= path_in_d;
      s1_q      <= path_out_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      trial_q   <= trial_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      timeout_q <= timeout_d;
    end
  end

  assign path_in_o = path_in_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign timeout_o = timeout_q;
  assign sum_cnt_o = sum_q;
  assign min_cnt_o = min_q;
  assign max_cnt_o = max_q;

endmodule
